// File: rtl/main_memory_responder.sv
// Fixed-latency line memory: one outstanding load/store, single-cycle response.
// Define MAIN_MEMORY_STORE_ACK_EN to also acknowledge stores with rsp_valid.
module main_memory_responder #(
    parameter int MEM_LATENCY = 10,
    parameter int LINE_WIDTH  = 128,
    parameter int NUM_LINES   = 256,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_is_store,
    input  logic [LINE_WIDTH-1:0] req_data,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [LINE_WIDTH-1:0] rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    localparam logic [7:0] LAT_M1 = 8'(MEM_LATENCY - 1);

    state_t                state;
    state_t                state_next;
    logic [7:0]            count;
    logic [7:0]            count_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  store_q;
    logic [LINE_WIDTH-1:0] data_q;
    logic                  accept;
    logic                  respond;

    logic [LINE_WIDTH-1:0] storage [NUM_LINES];

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign respond   = (state == RESPOND);

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    count_next = LAT_M1;
                    state_next = (MEM_LATENCY == 1) ? RESPOND : BUSY;
                end
            end
            BUSY: begin
                count_next = count - 8'd1;
                if (count <= 8'd1) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                count_next = 8'd0;
                state_next = IDLE;
            end
            default: begin
                count_next = 8'd0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 8'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            store_q <= 1'b0;
            data_q  <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            store_q <= req_is_store;
            data_q  <= req_data;
        end
    end

    // Storage is deliberately outside reset so contents survive it.
    always_ff @(posedge clock) begin
        if (respond && store_q) begin
            storage[addr_q] <= data_q;
        end
    end

`ifdef MAIN_MEMORY_STORE_ACK_EN
    assign rsp_valid = respond;
    assign rsp_data  = !respond ? '0
                     : store_q  ? data_q
                     : storage[addr_q];
`else
    assign rsp_valid = respond & ~store_q;
    assign rsp_data  = rsp_valid ? storage[addr_q] : '0;
`endif

endmodule
